pnr_window_discriminator: RTL and testbench

// Parametrised photon-number discriminator for the PNR path on ADC_CLK.

---
 rtl/pnr_window_discriminator_if.sv | 43 ++++
 rtl/pnr_window_discriminator.sv | 182 ++++++++++++++++++
 tb/tb_pnr_window_discriminator.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pnr_window_discriminator_if.sv
// Event-side bus of the PNR window discriminator: trigger, ADC sample, per-event config and results.
// The slave modport is the discriminator; the master modport drives trigger/config and consumes results.
interface pnr_window_discriminator_if #(
  parameter int DW     = 14,
  parameter int NLEVEL = 8,
  parameter int CW     = 4,
  parameter int HCW    = 32
);
  logic                     trigger;
  logic signed [DW-1:0]     pnr_source_sig;
  logic                     mode;
  logic [15:0]              delay_len;
  logic [15:0]              window_len;
  logic [15:0]              hold_len;
  logic [NLEVEL*DW-1:0]     thresholds;
  logic [NLEVEL:0]          dac_logic_mask;
  logic                     clear_cnt;
  logic [CW-1:0]            hist_sel;

  logic [NLEVEL:0]          pnr_onehot;
  logic [CW-1:0]            pnr_count;
  logic                     pnr_valid;
  logic                     busy;
  logic [DW-1:0]            dac_masked_GPIO;
  logic [DW-1:0]            adc_fifo_data;
  logic                     adc_fifo_wr_en;
  logic [15:0]              missed_trig_cnt;
  logic [HCW-1:0]           hist_data;

  modport master (
    output trigger, pnr_source_sig, mode, delay_len, window_len, hold_len,
           thresholds, dac_logic_mask, clear_cnt, hist_sel,
    input  pnr_onehot, pnr_count, pnr_valid, busy, dac_masked_GPIO,
           adc_fifo_data, adc_fifo_wr_en, missed_trig_cnt, hist_data
  );

  modport slave (
    input  trigger, pnr_source_sig, mode, delay_len, window_len, hold_len,
           thresholds, dac_logic_mask, clear_cnt, hist_sel,
    output pnr_onehot, pnr_count, pnr_valid, busy, dac_masked_GPIO,
           adc_fifo_data, adc_fifo_wr_en, missed_trig_cnt, hist_data
  );
endinterface

// File: rtl/pnr_window_discriminator.sv
// Photon-number discriminator: trigger -> delay -> sample/peak window -> classify; result at T+delay+W+2.
// No backpressure: triggers while busy are dropped and counted; PNR_HIST_EN adds per-bin histogram counters.
module pnr_window_discriminator #(
  parameter int DW     = 14,
  parameter int NLEVEL = 8,
  parameter int CW     = 4,
  parameter int HCW    = 32
) (
  input  logic                    ADC_CLK,
  input  logic                    rstn_i,
  pnr_window_discriminator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, INTEG, CLASSIFY} state_t;

  state_t               state;
  logic [15:0]          cnt_q;
  logic [15:0]          win_m1_q;
  logic [15:0]          hold_lat_q;
  logic [15:0]          hold_cnt_q;
  logic [NLEVEL*DW-1:0] thr_lat_q;
  logic signed [DW-1:0] peak_q;
  logic                 first_q;

  logic [NLEVEL:0]      onehot_q;
  logic [CW-1:0]        count_q;
  logic                 valid_q;
  logic [DW-1:0]        dac_q;
  logic [DW-1:0]        fifo_dat_q;
  logic [15:0]          missed_q;

  logic [15:0]          win_m1_in;
  logic [CW-1:0]        n_cls;
  logic [NLEVEL:0]      onehot_cls;
  logic                 gate_cls;
  logic                 trig_accept;

  localparam logic [DW-1:0] DAC_FULL = {1'b0, {(DW-1){1'b1}}};

  assign trig_accept = bus.trigger && (state == IDLE);

  // Window length 0 behaves as 1; single-sample mode always uses one cycle.
  always_comb begin
    win_m1_in = 16'd0;
    if (bus.mode && (bus.window_len != 16'd0))
      win_m1_in = bus.window_len - 16'd1;
  end

  always_comb begin
    n_cls = '0;
    for (int k = 0; k < NLEVEL; k++)
      if ($signed(thr_lat_q[k*DW +: DW]) < peak_q)
        n_cls = n_cls + CW'(1);
    onehot_cls        = '0;
    onehot_cls[n_cls] = 1'b1;
    gate_cls          = |(bus.dac_logic_mask & onehot_cls);
  end

  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      cnt_q      <= '0;
      win_m1_q   <= '0;
      hold_lat_q <= '0;
      hold_cnt_q <= '0;
      thr_lat_q  <= '0;
      peak_q     <= '0;
      first_q    <= 1'b0;
      onehot_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      dac_q      <= '0;
      fifo_dat_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (hold_cnt_q != 16'd0) begin
        hold_cnt_q <= hold_cnt_q - 16'd1;
        if (hold_cnt_q == 16'd1) begin
          onehot_q <= '0;
          count_q  <= '0;
          dac_q    <= '0;
        end
      end
      case (state)
        IDLE: begin
          if (trig_accept) begin
            win_m1_q   <= win_m1_in;
            hold_lat_q <= bus.hold_len;
            thr_lat_q  <= bus.thresholds;
            first_q    <= 1'b1;
            hold_cnt_q <= '0;
            onehot_q   <= '0;
            count_q    <= '0;
            dac_q      <= '0;
            fifo_dat_q <= '0;
            if (bus.delay_len == 16'd0) begin
              state <= INTEG;
              cnt_q <= win_m1_in;
            end else begin
              state <= WAIT;
              cnt_q <= bus.delay_len - 16'd1;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 16'd0) begin
            state <= INTEG;
            cnt_q <= win_m1_q;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        INTEG: begin
          first_q <= 1'b0;
          if (first_q || (bus.pnr_source_sig > peak_q))
            peak_q <= bus.pnr_source_sig;
          if (cnt_q == 16'd0)
            state <= CLASSIFY;
          else
            cnt_q <= cnt_q - 16'd1;
        end
        CLASSIFY: begin
          onehot_q   <= onehot_cls;
          count_q    <= n_cls;
          dac_q      <= gate_cls ? DAC_FULL : '0;
          fifo_dat_q <= peak_q;
          valid_q    <= 1'b1;
          hold_cnt_q <= hold_lat_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear has priority over a coincident dropped trigger.
  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i)
      missed_q <= '0;
    else if (bus.clear_cnt)
      missed_q <= '0;
    else if (bus.trigger && (state != IDLE) && (missed_q != 16'hFFFF))
      missed_q <= missed_q + 16'd1;
  end

  logic [HCW-1:0] hist_rd;

`ifdef PNR_HIST_EN
  logic [HCW-1:0] hist_q [NLEVEL+1];

  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int b = 0; b <= NLEVEL; b++)
        hist_q[b] <= '0;
      hist_rd <= '0;
    end else begin
      if (bus.clear_cnt) begin
        for (int b = 0; b <= NLEVEL; b++)
          hist_q[b] <= '0;
      end else if ((state == CLASSIFY) && (hist_q[n_cls] != {HCW{1'b1}})) begin
        hist_q[n_cls] <= hist_q[n_cls] + HCW'(1);
      end
      hist_rd <= (int'(bus.hist_sel) <= NLEVEL) ? hist_q[bus.hist_sel] : '0;
    end
  end
`else
  logic unused_hist_sel;
  assign unused_hist_sel = ^bus.hist_sel;
  assign hist_rd         = '0;
`endif

  assign bus.pnr_onehot      = onehot_q;
  assign bus.pnr_count       = count_q;
  assign bus.pnr_valid       = valid_q;
  assign bus.busy            = (state != IDLE);
  assign bus.dac_masked_GPIO = dac_q;
  assign bus.adc_fifo_data   = fifo_dat_q;
  assign bus.adc_fifo_wr_en  = valid_q;
  assign bus.missed_trig_cnt = missed_q;
  assign bus.hist_data       = hist_rd;

endmodule

// File: tb/tb_pnr_window_discriminator.sv
// Directed bench for pnr_window_discriminator with a queue scoreboard of expected results.
module tb_pnr_window_discriminator;

  logic ADC_CLK = 1'b0;
  logic rstn_i  = 1'b0;
  always #5 ADC_CLK = ~ADC_CLK;

  pnr_window_discriminator_if bus ();

  pnr_window_discriminator dut (
    .ADC_CLK (ADC_CLK),
    .rstn_i  (rstn_i),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0]  cnt;
    logic [8:0]  oh;
    logic [13:0] dat;
    logic [13:0] dac;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [111:0] thr_cfg;

  localparam int JUNK = 5000;

  always @(posedge ADC_CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ADC_CLK);
    #1;
  endtask

  function automatic int classify(input int v);
    int n = 0;
    for (int k = 0; k < 8; k++)
      if (100 * (k + 1) < v) n++;
    return n;
  endfunction

  // Scoreboard consumer: every write pulse must match the oldest expected result.
  always @(negedge ADC_CLK) begin
    if (rstn_i && (bus.pnr_valid || bus.adc_fifo_wr_en)) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_valid observed_at_cycle=%0d expected=none", cyc);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("valid", {31'd0, bus.pnr_valid}, 32'd1);
        chk("wr_en", {31'd0, bus.adc_fifo_wr_en}, 32'd1);
        chk("count", {28'd0, bus.pnr_count}, {28'd0, e.cnt});
        chk("onehot", {23'd0, bus.pnr_onehot}, {23'd0, e.oh});
        chk("fifo_data", {18'd0, bus.adc_fifo_data}, {18'd0, e.dat});
        chk("dac", {18'd0, bus.dac_masked_GPIO}, {18'd0, e.dac});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 8; i++) begin
      if (q.size() == 0) break;
      @(negedge ADC_CLK);
      #1;
    end
    chk("result_seen", q.size(), 0);
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
  endtask

  // One event; extra = sample index (0..W-1) or W (classify cycle) for a second trigger, -1 for none.
  task automatic run_event(input bit m, input int d, input int wcfg,
                           input int s0, input int s1, input int s2, input int s3,
                           input int extra);
    int   s[4];
    int   w, pk, n, t0;
    exp_t e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    w  = m ? ((wcfg == 0) ? 1 : wcfg) : 1;
    pk = s[0];
    for (int i = 1; i < w; i++)
      if (s[i] > pk) pk = s[i];
    n  = classify(pk);
    t0 = cyc;
    e.cnt = 4'(n);
    e.oh  = 9'(1 << n);
    e.dat = 14'(pk);
    e.dac = bus.dac_logic_mask[n] ? 14'h1FFF : 14'h0000;
    e.cyc = t0 + d + w + 2;
    q.push_back(e);

    bus.mode           = m;
    bus.delay_len      = 16'(d);
    bus.window_len     = 16'(wcfg);
    bus.thresholds     = thr_cfg;
    bus.pnr_source_sig = 14'(JUNK);
    bus.trigger        = 1'b1;
    tick();
    bus.trigger = 1'b0;
    chk("clear_onehot", {23'd0, bus.pnr_onehot}, 32'd0);
    chk("busy_start", {31'd0, bus.busy}, 32'd1);
    // Scramble config mid-event; the latched copy must be used.
    bus.mode       = ~m;
    bus.delay_len  = 16'(d + 5);
    bus.window_len = 16'(wcfg + 3);
    bus.thresholds = '0;
    for (int i = 0; i < d; i++) tick();
    for (int i = 0; i < w; i++) begin
      bus.pnr_source_sig = 14'(s[i]);
      bus.trigger        = (i == extra);
      tick();
    end
    bus.pnr_source_sig = 14'(JUNK);
    bus.trigger        = (extra == w);
    tick();
    bus.trigger    = 1'b0;
    bus.thresholds = thr_cfg;
    wait_done();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) thr_cfg[k*14 +: 14] = 14'(100 * (k + 1));
    bus.trigger        = 1'b0;
    bus.pnr_source_sig = '0;
    bus.mode           = 1'b0;
    bus.delay_len      = '0;
    bus.window_len     = '0;
    bus.hold_len       = '0;
    bus.thresholds     = thr_cfg;
    bus.dac_logic_mask = 9'h004;
    bus.clear_cnt      = 1'b0;
    bus.hist_sel       = '0;
    repeat (3) tick();
    chk("rst_onehot", {23'd0, bus.pnr_onehot}, 32'd0);
    chk("rst_count", {28'd0, bus.pnr_count}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_dac", {18'd0, bus.dac_masked_GPIO}, 32'd0);
    chk("rst_fifo", {18'd0, bus.adc_fifo_data}, 32'd0);
    chk("rst_missed", {16'd0, bus.missed_trig_cnt}, 32'd0);
    chk("rst_hist", bus.hist_data, 32'd0);
    rstn_i = 1'b1;
    tick();

    // Single sample after delay 3; hold_len 0 keeps the result.
    run_event(1'b0, 3, 0, 250, 0, 0, 0, -1);
    repeat (4) tick();
    chk("hold0_count", {28'd0, bus.pnr_count}, 32'd2);
    chk("hold0_dac", {18'd0, bus.dac_masked_GPIO}, 32'h1FFF);

    // Peak over window, including an all-negative window and window_len 0.
    run_event(1'b1, 0, 4, -50, 300, 820, 10, -1);
    run_event(1'b1, 2, 4, -300, -100, -200, -400, -1);
    run_event(1'b1, 1, 0, 450, 900, 900, 900, -1);

    // Threshold boundaries.
    run_event(1'b0, 1, 0, 100, 0, 0, 0, -1);
    run_event(1'b0, 1, 0, 200, 0, 0, 0, -1);
    run_event(1'b0, 2, 0, -8192, 0, 0, 0, -1);
    run_event(1'b0, 1, 0, 8191, 0, 0, 0, -1);

    // Dropped triggers during INTEG and during CLASSIFY.
    run_event(1'b1, 2, 4, 10, 20, 30, 40, 1);
    chk("missed_integ", {16'd0, bus.missed_trig_cnt}, 32'd1);
    bus.clear_cnt = 1'b1;
    tick();
    bus.clear_cnt = 1'b0;
    chk("missed_clear", {16'd0, bus.missed_trig_cnt}, 32'd0);
    run_event(1'b0, 1, 0, 450, 0, 0, 0, 1);
    chk("missed_classify", {16'd0, bus.missed_trig_cnt}, 32'd1);

    // Finite hold: result visible for exactly 2 cycles.
    bus.hold_len = 16'd2;
    run_event(1'b0, 1, 0, 250, 0, 0, 0, -1);
    tick();
    chk("hold2_dac_c2", {18'd0, bus.dac_masked_GPIO}, 32'h1FFF);
    chk("hold2_count_c2", {28'd0, bus.pnr_count}, 32'd2);
    tick();
    chk("hold2_dac_off", {18'd0, bus.dac_masked_GPIO}, 32'd0);
    chk("hold2_count_off", {28'd0, bus.pnr_count}, 32'd0);
    chk("hold2_onehot_off", {23'd0, bus.pnr_onehot}, 32'd0);
    bus.hold_len = 16'd0;

    // Histogram of bin 2 after three events.
    bus.clear_cnt = 1'b1;
    tick();
    bus.clear_cnt = 1'b0;
    for (int i = 0; i < 3; i++) run_event(1'b0, 0, 0, 250, 0, 0, 0, -1);
    bus.hist_sel = 4'd2;
    repeat (2) tick();
`ifdef PNR_HIST_EN
    chk("hist_bin2", bus.hist_data, 32'd3);
`else
    chk("hist_bin2", bus.hist_data, 32'd0);
`endif
    bus.hist_sel = 4'hF;
    repeat (2) tick();
    chk("hist_oob", bus.hist_data, 32'd0);

    // Reset in the middle of a window aborts the event.
    bus.mode           = 1'b1;
    bus.delay_len      = 16'd0;
    bus.window_len     = 16'd4;
    bus.trigger        = 1'b1;
    tick();
    bus.trigger        = 1'b0;
    bus.pnr_source_sig = 14'd900;
    repeat (2) tick();
    rstn_i = 1'b0;
    #2;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_valid", {31'd0, bus.pnr_valid}, 32'd0);
    chk("abort_count", {28'd0, bus.pnr_count}, 32'd0);
    chk("abort_fifo", {18'd0, bus.adc_fifo_data}, 32'd0);
    chk("abort_dac", {18'd0, bus.dac_masked_GPIO}, 32'd0);
    repeat (2) tick();
    rstn_i = 1'b1;
    repeat (8) tick();
    chk("abort_hist", bus.hist_data, 32'd0);
    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
